// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface program_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into imem words
// and holds the core in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module program_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  program_loader_if.master  bus,
  output logic              core_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t            state_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_buf_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   word_count_q;
  logic [7:0]        chk_q;
  logic              rx_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_waddr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              xfer;
  logic [15:0]       len_d;
  logic [ADDR_W:0]   word_count_d;
  logic              last_word;

  assign xfer         = bus.rx_valid & rx_ready_q;
  assign len_d        = {bus.rx_data, len_q[7:0]};
  assign word_count_d = word_count_q + 1'b1;
  assign last_word    = (16'(word_count_d) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      chk_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_LEN_LO;
            rx_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            core_reset_q <= 1'b1;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= bus.rx_data;
            state_q    <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= bus.rx_data;
            if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q      <= S_DONE;
              rx_ready_q   <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
`endif
            end else if ({1'b0, len_d} > CAPACITY) begin
              // Image cannot fit: refuse it without touching memory.
              state_q      <= S_DONE;
              rx_ready_q   <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              error_q      <= 1'b1;
              core_reset_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (!rx_ready_q) begin
            // Final write pulse is on the bus this cycle; finish one cycle later.
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            core_reset_q <= 1'b0;
          end else if (xfer) begin
            chk_q      <= chk_q ^ bus.rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: word_buf_q[7:0]   <= bus.rx_data;
              2'd1: word_buf_q[15:8]  <= bus.rx_data;
              2'd2: word_buf_q[23:16] <= bus.rx_data;
              default: begin
                imem_we_q    <= 1'b1;
                imem_wdata_q <= {bus.rx_data, word_buf_q};
                imem_waddr_q <= addr_q;
                addr_q       <= addr_q + 1'b1;
                word_count_q <= word_count_d;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
`else
                  rx_ready_q <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state_q      <= S_DONE;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            error_q      <= (bus.rx_data != chk_q);
            core_reset_q <= (bus.rx_data != chk_q);
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_reset_o   = core_reset_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as bytes are driven.
module tb_program_loader;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_reset, busy, done, error;
  logic [ADDR_W:0] word_count;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .bus          (bus),
    .core_reset_o (core_reset),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .word_count_o (word_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         mon_e;
  logic [31:0] img [0:63];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.imem_we) begin
      $display("[TB] write addr=%0d data=0x%08h", bus.imem_waddr, bus.imem_wdata);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("waddr", 32'(bus.imem_waddr), 32'(mon_e.addr));
        check_eq("wdata", bus.imem_wdata, mon_e.data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
    logic acc;
    int   t;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    start        = with_start;
    t = 0;
    do begin
      @(posedge clk);
      acc = bus.rx_ready;
      t++;
    end while (!acc && t < 64);
    #1;
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    if (!acc) check_eq("rx_accept_timeout", 32'd0, 32'd1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_image(input int n, input bit gap, input int start_idx);
    logic [15:0] len;
    logic [7:0]  x;
    logic [7:0]  b;
    wr_t         e;
    len = n[15:0];
    x   = 8'h00;
    send_byte(len[7:0], gap, 1'b0);
    send_byte(len[15:8], gap, 1'b0);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        x = x ^ b;
        if (k == 3) begin
          e.addr = w[ADDR_W-1:0];
          e.data = img[w];
          sb_q.push_back(e);
        end
        send_byte(b, gap, (w*4 + k) == start_idx);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, gap, 1'b0);
`endif
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_ok(input string tag, input int n);
    check_eq({tag, "_done"},       32'(done),       32'd1);
    check_eq({tag, "_error"},      32'(error),      32'd0);
    check_eq({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check_eq({tag, "_busy"},       32'(busy),       32'd0);
    check_eq({tag, "_word_count"}, 32'(word_count), n);
    check_eq({tag, "_sb_empty"},   sb_q.size(),     32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
    check_eq({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check_eq({tag, "_imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check_eq({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    check_eq({tag, "_core_reset"}, 32'(core_reset),     32'd1);
    check_eq({tag, "_busy"},       32'(busy),           32'd0);
    check_eq({tag, "_done"},       32'(done),           32'd0);
    check_eq({tag, "_error"},      32'(error),          32'd0);
    check_eq({tag, "_word_count"}, 32'(word_count),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-word image with exact completion timing.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    pulse_start();
    check_eq("start_rx_ready",   32'(bus.rx_ready), 32'd1);
    check_eq("start_busy",       32'(busy),         32'd1);
    check_eq("start_core_reset", 32'(core_reset),   32'd1);
    send_image(2, 1'b0, -1);
`ifndef LOADER_CHECKSUM_EN
    check_eq("last_we_pulse", 32'(bus.imem_we), 32'd1);
    check_eq("last_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq("last_we_drop", 32'(bus.imem_we), 32'd0);
`endif
    wait_done();
    check_ok("basic", 2);
    check_eq("basic_rx_ready_done", 32'(bus.rx_ready), 32'd0);

    // Same image with rx_valid toggling every cycle.
    pulse_start();
    send_image(2, 1'b1, -1);
    wait_done();
    check_ok("toggle", 2);

    // Length overflow, then recovery with a valid image.
    pulse_start();
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check_eq("ovf_error",      32'(error),      32'd1);
    check_eq("ovf_core_reset", 32'(core_reset), 32'd1);
    check_eq("ovf_word_count", 32'(word_count), 32'd0);
    pulse_start();
    check_eq("restart_error_clear", 32'(error), 32'd0);
    send_image(2, 1'b0, -1);
    wait_done();
    check_ok("recover", 2);

    // Asynchronous reset after two data bytes of the first word.
    pulse_start();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) img[i] = $urandom;
    pulse_start();
    send_image(5, 1'b0, -1);
    wait_done();
    check_ok("after_rst", 5);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a one-word image.
    img[0] = 32'h0000_0013;
    pulse_start();
    send_image(1, 1'b0, -1);
    wait_done();
    check_ok("chk_good", 1);
    pulse_start();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    mon_e.addr = '0;
    sb_q.push_back('{addr: '0, data: 32'h0000_0013});
    send_byte(8'h13, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    wait_done();
    check_eq("chk_bad_error",      32'(error),      32'd1);
    check_eq("chk_bad_core_reset", 32'(core_reset), 32'd1);
`endif

    // start pulsed mid-DATA must be ignored.
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    pulse_start();
    send_image(4, 1'b0, 6);
    wait_done();
    check_ok("start_in_data", 4);

    // Full-capacity image exercises the address range end to end.
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    pulse_start();
    send_image(64, 1'b0, -1);
    wait_done();
    check_ok("full", 64);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
